// File: rtl/alu_pkg.sv
// Operation codes shared by the ALU and the multi-precision sequencer.
// Only four codes are defined; other encodings pass through the sequencer unchanged.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3
  } alu_op_t;

endpackage

// File: rtl/alu_mp_sequencer_if.sv
// Command, response and ALU-drive signals of the multi-precision sequencer.
// The slave modport is the sequencer's view; the master modport is the requester/ALU side.
interface alu_mp_sequencer_if
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_WORDS  = 4
);

  localparam int W = DATA_WIDTH * NUM_WORDS;

  logic                  cmd_valid;
  logic                  cmd_ready;
  alu_op_t               cmd_op;
  logic [W-1:0]          cmd_a;
  logic [W-1:0]          cmd_b;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [W-1:0]          rsp_result;
  logic                  rsp_z;
  logic                  rsp_n;
  logic                  rsp_v;
  logic                  rsp_c;

  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  alu_op_t               alu_op;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_c;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready, alu_result, alu_c,
    output cmd_ready, rsp_valid, rsp_result, rsp_z, rsp_n, rsp_v, rsp_c,
           alu_a, alu_b, alu_op
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready, alu_result, alu_c,
    input  cmd_ready, rsp_valid, rsp_result, rsp_z, rsp_n, rsp_v, rsp_c,
           alu_a, alu_b, alu_op
  );

endinterface

// File: rtl/alu_mp_sequencer.sv
// Multi-precision sequencer: runs a wide ADD/SUB/AND/OR one ALU slice per cycle,
// rippling carry/borrow between slices with an extra +/-1 pass where a chain bit is pending.
module alu_mp_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_WORDS  = 4
) (
  input  logic                clk,
  input  logic                rst,
  alu_mp_sequencer_if.slave   bus
);

  localparam int W     = DATA_WIDTH * NUM_WORDS;
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PASS1,
    ST_PASS2,
    ST_RESP
  } state_t;

  state_t                state_q, state_d;
  alu_op_t               op_q, op_d;
  logic [W-1:0]          a_q, a_d;
  logic [W-1:0]          b_q, b_d;
  logic [W-1:0]          res_q, res_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  ci_q, ci_d;
  logic                  k1_q, k1_d;

  logic [DATA_WIDTH-1:0] a_slice, b_slice, res_slice;
  logic                  is_arith;
  logic                  is_resp;
  logic                  k;
  logic                  advance;

  assign a_slice   = a_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
  assign b_slice   = b_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
  assign res_slice = res_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
  assign is_arith  = (op_q == ALU_ADD) || (op_q == ALU_SUB);
  assign is_resp   = (state_q == ST_RESP);

  // The ALU's c is bit DATA_WIDTH of a sign-extended add/sub; undo the sign
  // extension to recover the unsigned carry (ADD) or borrow (SUB) of this pass.
  assign k = bus.alu_c ^ bus.alu_a[DATA_WIDTH-1] ^ bus.alu_b[DATA_WIDTH-1];

  // NOTE: data registers are reset as well, because rsp_result is visible and must read 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= ALU_AND;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      ci_q    <= 1'b0;
      k1_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      ci_q    <= ci_d;
      k1_q    <= k1_d;
    end
  end

  // ALU operand mux, kept apart from the FSM so the carry decode above reads settled operands.
  always_comb begin
    bus.alu_a  = '0;
    bus.alu_b  = '0;
    bus.alu_op = ALU_AND;
    unique case (state_q)
      ST_PASS1: begin
        bus.alu_a  = a_slice;
        bus.alu_b  = b_slice;
        bus.alu_op = op_q;
      end
      ST_PASS2: begin
        bus.alu_a  = res_slice;
        bus.alu_b  = DATA_WIDTH'(1);
        bus.alu_op = op_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d       = state_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    res_d         = res_q;
    idx_d         = idx_q;
    ci_d          = ci_q;
    k1_d          = k1_q;
    advance       = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          op_d    = bus.cmd_op;
          a_d     = bus.cmd_a;
          b_d     = bus.cmd_b;
          idx_d   = '0;
          ci_d    = 1'b0;
          state_d = ST_PASS1;
        end
      end
      ST_PASS1: begin
        res_d[idx_q*DATA_WIDTH +: DATA_WIDTH] = bus.alu_result;
        k1_d = k;
        if (is_arith && ci_q) begin
          state_d = ST_PASS2;
        end else begin
          ci_d    = is_arith & k;
          advance = 1'b1;
        end
      end
      ST_PASS2: begin
        // Folding the incoming chain bit can itself carry/borrow, but never together with k1.
        res_d[idx_q*DATA_WIDTH +: DATA_WIDTH] = bus.alu_result;
        ci_d    = k1_q | k;
        advance = 1'b1;
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      if (idx_q == LAST_IDX) begin
        state_d = ST_RESP;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = ST_PASS1;
      end
    end
  end

  assign bus.rsp_result = res_q;
  assign bus.rsp_z      = is_resp && (res_q == '0);
  assign bus.rsp_n      = is_resp && res_q[W-1];
  assign bus.rsp_c      = is_resp && is_arith && ci_q;
  assign bus.rsp_v      = is_resp && (
                            ((op_q == ALU_ADD) && (a_q[W-1] == b_q[W-1]) && (res_q[W-1] != a_q[W-1])) ||
                            ((op_q == ALU_SUB) && (a_q[W-1] != b_q[W-1]) && (res_q[W-1] != a_q[W-1])));

endmodule

// File: tb/tb_alu_mp_sequencer.sv
// Self-checking bench for alu_mp_sequencer: directed table, stall/reset sequences,
// and random commands compared with a whole-word arithmetic reference model.
module tb_alu_mp_sequencer;
  import alu_pkg::*;

  localparam int DW   = 4;
  localparam int NW   = 4;
  localparam int W    = DW * NW;
  localparam int MAXL = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_mp_sequencer_if #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) bus ();

  alu_mp_sequencer #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Combinational ALU: c is bit DW of the sign-extended add/sub, 0 for logic ops.
  logic [DW:0] alu_ext;
  always_comb begin
    alu_ext = '0;
    case (bus.alu_op)
      ALU_ADD: alu_ext = {bus.alu_a[DW-1], bus.alu_a} + {bus.alu_b[DW-1], bus.alu_b};
      ALU_SUB: alu_ext = {bus.alu_a[DW-1], bus.alu_a} - {bus.alu_b[DW-1], bus.alu_b};
      ALU_AND: alu_ext = {1'b0, bus.alu_a & bus.alu_b};
      ALU_OR:  alu_ext = {1'b0, bus.alu_a | bus.alu_b};
      default: alu_ext = '0;
    endcase
    bus.alu_result = alu_ext[DW-1:0];
    bus.alu_c      = alu_ext[DW];
  end

  typedef struct {
    alu_op_t      op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic [3:0]   f;   // {z, n, v, c}
    int           p;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Whole-word reference: plain integer arithmetic, pass count from the carries into each slice.
  function automatic void model(input alu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic [3:0] f, output int p);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint lim = longint'(1) << (W - 1);
    longint s;
    logic   c = 1'b0;
    logic   v = 1'b0;
    p = NW;
    case (op)
      ALU_ADD: begin
        s = ua + ub;
        r = s[W-1:0];
        c = (s >= (longint'(1) << W));
        s = sa + sb;
        v = (s >= lim) || (s < -lim);
        for (int i = 1; i < NW; i++) begin
          longint m = longint'(1) << (DW * i);
          if ((ua % m) + (ub % m) >= m) p++;
        end
      end
      ALU_SUB: begin
        s = ua - ub;
        r = s[W-1:0];
        c = (ua < ub);
        s = sa - sb;
        v = (s >= lim) || (s < -lim);
        for (int i = 1; i < NW; i++) begin
          longint m = longint'(1) << (DW * i);
          if ((ua % m) < (ub % m)) p++;
        end
      end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      default: r = '0;
    endcase
    f = {(r == '0), r[W-1], v, c};
  endfunction

  // Issue one command from IDLE; return the response fields and accept-to-rsp_valid cycles.
  task automatic run_cmd(input alu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic [3:0] f, output int lat);
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat <= MAXL) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = bus.rsp_result;
    f = {bus.rsp_z, bus.rsp_n, bus.rsp_v, bus.rsp_c};
  endtask

  function automatic alu_op_t rand_op();
    int sel = int'($urandom_range(0, 4));
    return (sel == 4) ? alu_op_t'(3'd5) : alu_op_t'(3'(sel));
  endfunction

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  vec_t         tbl [10];
  logic [W-1:0] got_r, exp_r;
  logic [3:0]   got_f, exp_f;
  int           lat, exp_p, seen;

  initial begin
    tbl[0] = '{ALU_ADD,        16'h00FF, 16'h0001, 16'h0100, 4'b0000, 6};
    tbl[1] = '{ALU_ADD,        16'hFFFF, 16'h0001, 16'h0000, 4'b1001, 7};
    tbl[2] = '{ALU_SUB,        16'h8000, 16'h0001, 16'h7FFF, 4'b0010, 7};
    tbl[3] = '{ALU_SUB,        16'h0000, 16'h0001, 16'hFFFF, 4'b0101, 7};
    tbl[4] = '{ALU_ADD,        16'h7FFF, 16'h0001, 16'h8000, 4'b0110, 7};
    tbl[5] = '{ALU_AND,        16'hF0F0, 16'hFF00, 16'hF000, 4'b0100, 4};
    tbl[6] = '{ALU_OR,         16'h0000, 16'h0000, 16'h0000, 4'b1000, 4};
    tbl[7] = '{alu_op_t'(3'd6), 16'h1234, 16'h5678, 16'h0000, 4'b1000, 4};
    tbl[8] = '{ALU_SUB,        16'h1234, 16'h1234, 16'h0000, 4'b1000, 4};
    tbl[9] = '{ALU_ADD,        16'h8000, 16'h8000, 16'h0000, 4'b1011, 4};

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = ALU_ADD;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.rsp_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("reset_handshake", {bus.cmd_ready, bus.rsp_valid}, 2'b10);
    check("reset_rsp", {bus.rsp_result, bus.rsp_z, bus.rsp_n, bus.rsp_v, bus.rsp_c}, '0);
    check("reset_alu_drive", {bus.alu_a, bus.alu_b, bus.alu_op}, {{(2*DW){1'b0}}, ALU_AND});
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      run_cmd(tbl[i].op, tbl[i].a, tbl[i].b, got_r, got_f, lat);
      check($sformatf("tbl%0d_result", i), got_r, tbl[i].r);
      check($sformatf("tbl%0d_flags", i), got_f, tbl[i].f);
      check($sformatf("tbl%0d_latency", i), lat, tbl[i].p);
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_back_idle", i), {bus.rsp_valid, bus.cmd_ready}, 2'b01);
    end

    // Response stall: outputs frozen, cmd_ready low, stray commands ignored.
    bus.rsp_ready = 1'b0;
    run_cmd(ALU_SUB, 16'h8000, 16'h0001, got_r, got_f, lat);
    check("stall_latency", lat, 7);
    for (int c = 0; c < 5; c++) begin
      bus.cmd_valid = c[0] ? 1'b0 : 1'b1;
      bus.cmd_op    = ALU_OR;
      bus.cmd_a     = 16'hAAAA;
      bus.cmd_b     = 16'h5555;
      @(posedge clk);
      #1;
      check($sformatf("stall_hold%0d", c),
            {bus.rsp_valid, bus.cmd_ready, bus.rsp_result, bus.rsp_z, bus.rsp_n, bus.rsp_v, bus.rsp_c},
            {2'b10, 16'h7FFF, 4'b0010});
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall_release", {bus.rsp_valid, bus.cmd_ready}, 2'b01);
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) seen++;
    end
    check("stall_no_extra_rsp", seen, 0);

    // Reset in the middle of a carry-chained command.
    bus.cmd_op    = ALU_ADD;
    bus.cmd_a     = 16'hFFFF;
    bus.cmd_b     = 16'h0001;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midreset_state",
          {bus.cmd_ready, bus.rsp_valid, bus.rsp_result, bus.alu_a, bus.alu_b, bus.alu_op},
          {2'b10, 16'h0000, {(2*DW){1'b0}}, ALU_AND});
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) seen++;
    end
    check("midreset_no_rsp", seen, 0);
    run_cmd(tbl[0].op, tbl[0].a, tbl[0].b, got_r, got_f, lat);
    check("postreset_result", {got_r, got_f}, {tbl[0].r, tbl[0].f});
    check("postreset_latency", lat, tbl[0].p);
    @(posedge clk);
    #1;

    // Random commands against the reference model.
    for (int t = 0; t < 60; t++) begin
      alu_op_t      op = rand_op();
      logic [W-1:0] a  = rand_operand();
      logic [W-1:0] b  = rand_operand();
      model(op, a, b, exp_r, exp_f, exp_p);
      run_cmd(op, a, b, got_r, got_f, lat);
      check($sformatf("rnd%0d_result op=%0d a=%h b=%h", t, op, a, b), got_r, exp_r);
      check($sformatf("rnd%0d_flags op=%0d a=%h b=%h", t, op, a, b), got_f, exp_f);
      check($sformatf("rnd%0d_latency op=%0d a=%h b=%h", t, op, a, b), lat, exp_p);
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_mp_sequencer.md
# alu_mp_sequencer

Multi-precision arithmetic sequencer that drives an external `alu` instance, the requesting end of the ALU's `a`/`b`/`op` → `result`/flags interface. It accepts wide commands (`NUM_WORDS` slices of `DATA_WIDTH` bits) over a valid/ready handshake. It feeds the ALU one slice per cycle, chaining carry/borrow across slices with an extra ALU pass where needed. It returns the full-width result and flags over a valid/ready response channel.

## Interface

Parameters:
- `DATA_WIDTH`, default 4: ALU slice width; must match the attached ALU.
- `NUM_WORDS`, default 4: slices per operand. `W = DATA_WIDTH*NUM_WORDS`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command valid.
- `cmd_ready`  out  1  command accept; high only in IDLE.
- `cmd_op`  in  `alu_op_t`  ALU_ADD / ALU_SUB / ALU_AND / ALU_OR (`alu_pkg`).
- `cmd_a`, `cmd_b`  in  W  operands.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_result`  out  W  full-width result.
- `rsp_z`, `rsp_n`, `rsp_v`, `rsp_c`  out  1  full-width zero, negative, signed-overflow and carry/borrow flags.
- `alu_a`, `alu_b`  out  DATA_WIDTH  ALU operands.
- `alu_op`  out  `alu_op_t`  ALU operation.
- `alu_result`  in  DATA_WIDTH  ALU result (combinational from `alu_a`/`alu_b`/`alu_op`).
- `alu_c`  in  1  ALU c flag. ALU `z`/`n`/`v` are not used.

## Operation

- The ALU c flag is bit `DATA_WIDTH` of the sign-extended add/sub. The unsigned carry (ADD) or borrow (SUB) of a pass is `k = alu_c ^ alu_a[MSB] ^ alu_b[MSB]`.
- **States:** IDLE, PASS1, PASS2, RESP.
- **IDLE**
  - `cmd_ready=1`.
  - On `cmd_valid & cmd_ready`: capture op/a/b, word index `i=0`, chain bit `ci=0`, go to PASS1.
- **PASS1**
  - Drive `alu_a=a[i]`, `alu_b=b[i]`, `alu_op=op`.
  - Register `alu_result` into slice i and `k1=k`.
  - If op is ADD/SUB and `ci=1`, go to PASS2. Otherwise set `ci=k1` (0 for logic ops) and advance.
- **PASS2**
  - Drive `alu_a` = registered slice i, `alu_b=1`, `alu_op=op` (add 1 / subtract 1).
  - Register the result into slice i.
  - Set `ci = k1 | k` and advance.
- **Advance:** if `i==NUM_WORDS-1`, go to RESP; else `i++` and go to PASS1.
- **RESP**
  - `rsp_valid=1`, all `rsp_*` held stable.
  - On `rsp_ready`, go to IDLE. `cmd_ready` rises the following cycle.
- **Flags**
  - `rsp_z`: full W-bit result == 0.
  - `rsp_n`: result[W-1].
  - `rsp_c`: final `ci` for ADD/SUB; 0 for logic ops.
  - `rsp_v` for ADD: `a[W-1]==b[W-1]` and `r[W-1]!=a[W-1]`.
  - `rsp_v` for SUB: `a[W-1]!=b[W-1]` and `r[W-1]!=a[W-1]`.
  - `rsp_v` is 0 for logic ops.
- **Other ops:** any op outside the four defined is forwarded unchanged. The ALU returns 0, so the response is result 0, `z=1`, `n=c=v=0`.
- **Idle drive:** outside PASS1/PASS2, drive `alu_a=alu_b='0` and `alu_op=ALU_AND`.
- **Reset, at any time:**
  - Go to IDLE; any in-flight command is dropped and no response is produced.
  - `cmd_ready=1`, `rsp_valid=0`, `rsp_result='0`, all `rsp_*` flags 0, `alu_*` outputs at idle drive.

## Timing

- One ALU pass per cycle. The ALU is combinational, so its result is registered at the end of the same cycle.
- Pass count P = `NUM_WORDS` + (number of slices i ≥ 1 entered with `ci=1`, ADD/SUB only). Slice 0 never takes PASS2.
- Latency: `rsp_valid` rises exactly P cycles after the accepting edge.
  - P ranges from `NUM_WORDS` to `2*NUM_WORDS-1`.
- Minimum command spacing: P+2 cycles (RESP with `rsp_ready` already high, then IDLE).
- `cmd_valid` while busy is ignored; `cmd_ready=0` outside IDLE.
- `rsp_ready` low stalls indefinitely in RESP with outputs unchanged.

## Test plan

All scenarios use `DATA_WIDTH=4`, `NUM_WORDS=4`.

1. ADD 0x00FF+0x0001 -> result 0x0100, `z=n=v=c=0`, `rsp_valid` 6 cycles after accept.
2. ADD 0xFFFF+0x0001 -> result 0x0000, `z=1`, `c=1`, `n=v=0`, P=7.
3. SUB 0x8000-0x0001 -> result 0x7FFF, `v=1`, `c=0`, `n=0`, P=7. Also SUB 0x0000-0x0001 -> 0xFFFF, `c=1`, `n=1`.
4. ADD 0x7FFF+0x0001 -> result 0x8000, `v=1`, `n=1`, `c=0`.
5. AND 0xF0F0&0xFF00 -> result 0xF000, `n=1`; OR 0x0000|0x0000 -> `z=1`. Both P=4, `c=v=0`.
6. Handshake and reset:
   - Hold `rsp_ready` low 5 cycles: response stable, `cmd_ready=0`, extra `cmd_valid` pulses ignored.
   - Assert `rst` mid-PASS: IDLE next, no `rsp_valid`, next command runs correctly.
